// File: rtl/haar_inv_1d.sv
// Inverse 1-D Haar stage: rebuilds 8 pixels from 4 averages + 4 differences.
// Two-stage valid/ready pipeline with row-word tracking and a sticky clamp flag.

module haar_inv_s1_lane (
   input  logic [7:0] a_i,
   input  logic [7:0] d_i,
   output logic [9:0] x1_o
);
   logic [9:0] a_ext;
   logic [9:0] d_half;

   assign a_ext  = {2'b00, a_i};
   // floor(d/2) for an 8-bit two's-complement d, sign-extended to 10 bits
   assign d_half = {{3{d_i[7]}}, d_i[7:1]};
   assign x1_o   = a_ext - d_half;
endmodule

module haar_inv_s2_lane (
   input  logic [9:0]  x1_i,
   input  logic [7:0]  d_i,
   output logic [15:0] pix_o,
   output logic        sat_o
);
   logic [9:0] x0;
   logic [7:0] px0, px1;
   logic       sat0, sat1;

   assign x0 = x1_i + {{2{d_i[7]}}, d_i};

   always_comb begin
      px0  = x0[7:0];
      sat0 = 1'b0;
      if (x0[9]) begin
         px0  = 8'h00;
         sat0 = 1'b1;
      end else if (x0[8]) begin
         px0  = 8'hFF;
         sat0 = 1'b1;
      end
   end

   always_comb begin
      px1  = x1_i[7:0];
      sat1 = 1'b0;
      if (x1_i[9]) begin
         px1  = 8'h00;
         sat1 = 1'b1;
      end else if (x1_i[8]) begin
         px1  = 8'hFF;
         sat1 = 1'b1;
      end
   end

   assign pix_o = {px1, px0};
   assign sat_o = sat0 | sat1;
endmodule

module haar_inv_1d #(
   parameter int ROW_WORDS = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [63:0] coef_in,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [63:0] pix_out,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        row_last,
   output logic        sat_err,
   input  logic        sat_clr
);
   localparam int NUM_LANES = 4;
   localparam int CW        = 16;

   typedef struct packed {
      logic [9:0] x1;
      logic [7:0] d;
   } s1_lane_t;

   logic [NUM_LANES-1:0][7:0]  avg, dif;
   logic [NUM_LANES-1:0][9:0]  x1_calc;
   logic [NUM_LANES-1:0][15:0] pix_calc;
   logic [NUM_LANES-1:0]       lane_sat;

   s1_lane_t [NUM_LANES-1:0] s1_d, s1_q;
   logic                     s1_valid_d, s1_valid_q;
   logic                     s1_last_d, s1_last_q;
   logic [63:0]              pix_d, pix_q;
   logic                     out_valid_d, out_valid_q;
   logic                     row_last_d, row_last_q;
   logic                     sat_err_d, sat_err_q;
   logic [CW-1:0]            cnt_d, cnt_q;

   logic s1_adv, s2_adv, accept, s2_load, cnt_wrap;

   assign s2_adv   = !out_valid_q | out_ready;
   assign s1_adv   = !s1_valid_q | s2_adv;
   assign accept   = in_valid & s1_adv;
   assign s2_load  = s2_adv & s1_valid_q;
   assign cnt_wrap = (cnt_q == CW'(ROW_WORDS - 1));

   genvar i;
   generate
      for (i = 0; i < NUM_LANES; i++) begin : g_lane
         assign avg[i] = coef_in[8*i +: 8];
         assign dif[i] = coef_in[8*i+32 +: 8];

         haar_inv_s1_lane u_s1 (
            .a_i  (avg[i]),
            .d_i  (dif[i]),
            .x1_o (x1_calc[i])
         );

         haar_inv_s2_lane u_s2 (
            .x1_i  (s1_q[i].x1),
            .d_i   (s1_q[i].d),
            .pix_o (pix_calc[i]),
            .sat_o (lane_sat[i])
         );
      end
   endgenerate

   always_comb begin
      s1_d       = s1_q;
      s1_last_d  = s1_last_q;
      s1_valid_d = s1_valid_q;
      cnt_d      = cnt_q;
      if (s1_adv) s1_valid_d = in_valid;
      if (accept) begin
         for (int l = 0; l < NUM_LANES; l++) begin
            s1_d[l].x1 = x1_calc[l];
            s1_d[l].d  = dif[l];
         end
         s1_last_d = cnt_wrap;
         cnt_d     = cnt_wrap ? '0 : cnt_q + 1'b1;
      end
   end

   always_comb begin
      pix_d       = pix_q;
      row_last_d  = row_last_q;
      out_valid_d = out_valid_q;
      if (s2_adv) out_valid_d = s1_valid_q;
      if (s2_load) begin
         pix_d      = pix_calc;
         row_last_d = s1_last_q;
      end
   end

   // A saturated word landing in stage 2 beats a coincident clear
   always_comb begin
      sat_err_d = sat_err_q & ~sat_clr;
      if (s2_load && (|lane_sat)) sat_err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q        <= '0;
         s1_valid_q  <= 1'b0;
         s1_last_q   <= 1'b0;
         cnt_q       <= '0;
         pix_q       <= '0;
         out_valid_q <= 1'b0;
         row_last_q  <= 1'b0;
         sat_err_q   <= 1'b0;
      end else begin
         s1_q        <= s1_d;
         s1_valid_q  <= s1_valid_d;
         s1_last_q   <= s1_last_d;
         cnt_q       <= cnt_d;
         pix_q       <= pix_d;
         out_valid_q <= out_valid_d;
         row_last_q  <= row_last_d;
         sat_err_q   <= sat_err_d;
      end
   end

   assign in_ready  = s1_adv;
   assign pix_out   = pix_q;
   assign out_valid = out_valid_q;
   assign row_last  = row_last_q;
   assign sat_err   = sat_err_q;
endmodule
